// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// One command is in flight at a time; reads return on the winner's rvalid.
module dm_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                cmd_port_q, cmd_port_d;
  logic                last_port_q, last_port_d;
  logic                win_s;

  // State and command registers; last_port resets to 1 so the first tie goes to port 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_port_q  <= 1'b0;
      last_port_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_port_q  <= cmd_port_d;
      last_port_q <= last_port_d;
    end
  end

  // Round-robin pick plus next-state; arbitration is live in IDLE and RESP
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_port_d  = cmd_port_q;
    last_port_d = last_port_q;

    if (req0 && req1) begin
      win_s = ~last_port_q;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end

    case (state_q)
      IDLE, RESP: begin
        if (req0 || req1) begin
          cmd_we_d    = win_s ? we1    : we0;
          cmd_addr_d  = win_s ? addr1  : addr0;
          cmd_wdata_d = win_s ? wdata1 : wdata0;
          cmd_port_d  = win_s;
          last_port_d = win_s;
          state_d     = CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (cmd_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; everything is zero outside the state that owns it
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      CMD: begin
        mem_en    = 1'b1;
        mem_we    = cmd_we_q;
        mem_addr  = cmd_addr_q;
        mem_wdata = cmd_wdata_q;
        gnt0      = ~cmd_port_q;
        gnt1      = cmd_port_q;
      end
      RESP: begin
        rvalid0 = ~cmd_port_q;
        rvalid1 = cmd_port_q;
        if (cmd_port_q) begin
          rdata1 = mem_rdata;
        end else begin
          rdata0 = mem_rdata;
        end
      end
      default: begin
        gnt0 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed scenarios plus random traffic scored
// against a transaction-level timing model and a shadow memory.
module tb_dm_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory standing in for dm
  logic [DW-1:0] dm [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dm[mem_addr] <= mem_wdata;
      else        mem_rdata    <= dm[mem_addr];
    end
  end

  // Reference model: a granted command owns the memory for two cycles
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc, free_cyc, cmd_cyc, rsp_cyc;
  bit            last_p, cmd_p, rsp_p, cmd_we_m;
  logic [AW-1:0] cmd_addr_m;
  logic [DW-1:0] cmd_wdata_m, rsp_data;
  logic [DW-1:0] ref_mem [0:1023];
  logic [111:0]  exp_b;

  function automatic logic [111:0] obs();
    return {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata, rdata0, rdata1};
  endfunction

  task automatic model_reset();
    free_cyc = cyc;
    cmd_cyc  = -10;
    rsp_cyc  = -10;
    last_p   = 1'b1;
  endtask

  task automatic model_arb();
    bit w;
    if (cyc >= free_cyc && (req0 || req1)) begin
      w           = (req0 && req1) ? !last_p : req1;
      last_p      = w;
      cmd_p       = w;
      cmd_cyc     = cyc + 1;
      cmd_we_m    = w ? we1 : we0;
      cmd_addr_m  = w ? addr1 : addr0;
      cmd_wdata_m = w ? wdata1 : wdata0;
      if (cmd_we_m) begin
        ref_mem[cmd_addr_m] = cmd_wdata_m;
      end else begin
        rsp_cyc  = cyc + 2;
        rsp_p    = w;
        rsp_data = ref_mem[cmd_addr_m];
      end
      free_cyc = cyc + 2;
    end
  endtask

  task automatic model_expect();
    logic          g0, g1, v0, v1, en, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd0, rd1;
    {g0, g1, v0, v1, en, we} = 6'b0;
    a = '0; wd = '0; rd0 = '0; rd1 = '0;
    if (cmd_cyc == cyc) begin
      g0 = !cmd_p; g1 = cmd_p; en = 1'b1; we = cmd_we_m; a = cmd_addr_m; wd = cmd_wdata_m;
    end
    if (rsp_cyc == cyc) begin
      v0 = !rsp_p; v1 = rsp_p;
      if (rsp_p) rd1 = rsp_data;
      else       rd0 = rsp_data;
    end
    exp_b = {g0, g1, v0, v1, en, we, a, wd, rd0, rd1};
  endtask

  task automatic advance();
    @(negedge clk);
    cyc++;
    model_expect();
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    model_reset();
    model_arb();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd9; req1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (obs() !== 112'd0) begin
        miscompares++;
        $display("FAIL reset_state: got %h want 0", obs());
      end
    end
    clear_inputs();
    rst = 1'b1;
    cyc = 0;
    model_reset();
    model_arb();
  endtask

  task automatic test_write();
    advance();
    vectors++;
    if (obs() !== exp_b) begin miscompares++; $display("FAIL write_pre cyc %0d: got %h want %h", cyc, obs(), exp_b); end
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd2; wdata0 = 32'h00030002;
    model_arb();
    advance();
    vectors++;
    if (!(gnt0 === 1'b1 && gnt1 === 1'b0 && mem_en === 1'b1 && mem_we === 1'b1 &&
          mem_addr === 10'd2 && mem_wdata === 32'h00030002)) begin
      miscompares++;
      $display("FAIL write_cmd: got gnt0=%b en=%b we=%b addr=%0d wdata=%h want 1 1 1 2 00030002",
               gnt0, mem_en, mem_we, mem_addr, mem_wdata);
    end
    req0 = 1'b0;
    model_arb();
    for (int k = 0; k < 3; k++) begin
      advance();
      vectors++;
      if (obs() !== exp_b || rvalid0 !== 1'b0 || mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL write_after cyc %0d: got %h want %h", cyc, obs(), exp_b);
      end
      model_arb();
    end
  endtask

  task automatic test_read();
    advance();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1;
    model_arb();
    advance();
    vectors++;
    if (!(gnt0 === 1'b1 && mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 10'd1) || obs() !== exp_b) begin
      miscompares++;
      $display("FAIL read_gnt: got %h want %h", obs(), exp_b);
    end
    req0 = 1'b0;
    model_arb();
    advance();
    vectors++;
    if (!(rvalid0 === 1'b1 && rdata0 === 32'd1 && rvalid1 === 1'b0 && rdata1 === 32'd0)) begin
      miscompares++;
      $display("FAIL read_data: got rvalid0=%b rdata0=%h rvalid1=%b want 1 00000001 0", rvalid0, rdata0, rvalid1);
    end
    model_arb();
    advance();
    vectors++;
    if (obs() !== exp_b) begin miscompares++; $display("FAIL read_idle: got %h want %h", obs(), exp_b); end
    model_arb();
  endtask

  task automatic test_tie();
    logic g0, g1, v0, v1;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd5;
    model_arb();
    for (int k = 1; k <= 8; k++) begin
      advance();
      g0 = (k == 1 || k == 5);
      g1 = (k == 3 || k == 7);
      v0 = (k == 2 || k == 6);
      v1 = (k == 4 || k == 8);
      vectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1} !== {g0, g1, v0, v1} || obs() !== exp_b) begin
        miscompares++;
        $display("FAIL tie_seq k=%0d: got g/v=%b%b%b%b want %b%b%b%b", k, gnt0, gnt1, rvalid0, rvalid1, g0, g1, v0, v1);
      end
      if ((v0 && rdata0 !== 32'd4) || (v1 && rdata1 !== 32'd5)) begin
        miscompares++;
        $display("FAIL tie_data k=%0d: got rdata0=%h rdata1=%h want 4/5", k, rdata0, rdata1);
      end
      if (k == 8) clear_inputs();
      model_arb();
    end
    advance();
    model_arb();
  endtask

  task automatic test_wr_order();
    bit seen = 1'b0;
    advance();
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd7; wdata1 = 32'hDEADBEEF;
    model_arb();
    for (int k = 0; k < 8; k++) begin
      advance();
      vectors++;
      if (obs() !== exp_b) begin miscompares++; $display("FAIL order cyc %0d: got %h want %h", cyc, obs(), exp_b); end
      if (gnt1 === 1'b1) begin
        req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'd7;
      end
      if (gnt0 === 1'b1) req0 = 1'b0;
      if (rvalid0 === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (rdata0 !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL order_data: got %h want deadbeef", rdata0);
        end
      end
      model_arb();
    end
    if (!seen) begin miscompares++; $display("FAIL order_timeout: got no rvalid0 want one"); end
  endtask

  task automatic test_reset_mid_read();
    bit seen = 1'b0;
    advance();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3;
    model_arb();
    for (int k = 0; k < 6 && !seen; k++) begin
      advance();
      vectors++;
      if (obs() !== exp_b) begin miscompares++; $display("FAIL midrst_pre cyc %0d: got %h want %h", cyc, obs(), exp_b); end
      if (gnt0 === 1'b1) req0 = 1'b0;
      if (rvalid0 === 1'b1) seen = 1'b1;
      else model_arb();
    end
    if (!seen) begin miscompares++; $display("FAIL midrst_timeout: got no rvalid0 want one"); end
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs() !== 112'd0) begin miscompares++; $display("FAIL midrst_drop: got %h want 0", obs()); end
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    model_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd5;
    model_arb();
    for (int k = 1; k <= 5; k++) begin
      advance();
      vectors++;
      if (obs() !== exp_b || (k == 1 && (gnt0 !== 1'b1 || gnt1 !== 1'b0))) begin
        miscompares++;
        $display("FAIL midrst_after k=%0d: got %h want %h", k, obs(), exp_b);
      end
      if (gnt0 === 1'b1) req0 = 1'b0;
      if (gnt1 === 1'b1) req1 = 1'b0;
      model_arb();
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      advance();
      vectors++;
      if (obs() !== exp_b || mem_en !== 1'b0 || mem_addr !== 10'd0 ||
          {gnt0, gnt1, rvalid0, rvalid1} !== 4'b0) begin
        miscompares++;
        $display("FAIL idle cyc %0d: got %h want %h", cyc, obs(), exp_b);
      end
      clear_inputs();
      we0 = 1'($urandom_range(1)); addr0 = 10'($urandom_range(1023)); wdata1 = $urandom;
      model_arb();
    end
  endtask

  task automatic drive_random(int pct);
    bit g0now, g1now;
    g0now = (cmd_cyc == cyc && cmd_p == 1'b0);
    g1now = (cmd_cyc == cyc && cmd_p == 1'b1);
    if (!req0 || g0now) begin
      req0 = ($urandom_range(99) < pct);
      we0 = 1'($urandom_range(1)); addr0 = 10'($urandom_range(15)); wdata0 = $urandom;
    end
    if (!req1 || g1now) begin
      req1 = ($urandom_range(99) < pct);
      we1 = 1'($urandom_range(1)); addr1 = 10'($urandom_range(15)); wdata1 = $urandom;
    end
  endtask

  task automatic test_random();
    int pcts [3] = '{30, 70, 100};
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 600; k++) begin
        advance();
        vectors++;
        if (obs() !== exp_b) begin
          miscompares++;
          $display("FAIL random pct=%0d cyc %0d: got %h want %h", pcts[p], cyc, obs(), exp_b);
        end
        drive_random(pcts[p]);
        model_arb();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dm[i]      = 32'(i);
      ref_mem[i] = 32'(i);
    end
    cyc = 0;
    model_reset();
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_wr_order();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port synchronous data memory (`dm`) between two requesters: port 0 is the CPU load/store unit, port 1 is the memory loader/debug port.
- Requests are arbitrated round-robin, latched, and issued to memory one at a time. Read data returns on the requester's rvalid.
- Sits between `my_cpu` and `dm`. The CPU stalls while its request is pending and ungranted.

Parameters:
- ADDR_W, 10, word-address width of `dm`.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0  in  1  port 0 (CPU) access request; held until gnt0.
- we0  in  1  port 0 write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 store data.
- gnt0  out  1  one-cycle pulse: port 0 command issued to memory this cycle.
- rvalid0  out  1  one-cycle pulse: rdata0 valid (loads only).
- rdata0  out  DATA_W  port 0 load data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (loader).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- FSM states: IDLE, CMD, RESP.
- Registered state: state, cmd_we, cmd_addr, cmd_wdata, cmd_port, last_port.
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_port = 1, all cmd registers = 0.
  - gnt*, rvalid*, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata* = 0.
  - Any in-flight access is dropped: no gnt or rvalid is produced for it after reset releases.
- Arbitration runs in IDLE and RESP:
  - Only one of req0/req1 high: that port wins.
  - Both high: the port != last_port wins. First tie after reset goes to port 0.
  - Winner's we/addr/wdata are latched into cmd_*; cmd_port and last_port are set to the winner; next state = CMD.
  - No request: IDLE stays IDLE; RESP goes to IDLE.
- CMD (exactly one cycle):
  - mem_en = 1, mem_we = cmd_we, mem_addr = cmd_addr, mem_wdata = cmd_wdata.
  - gnt[cmd_port] = 1.
  - Next state: RESP if cmd_we = 0, else IDLE.
- RESP (read return):
  - rvalid[cmd_port] = 1 and rdata[cmd_port] = mem_rdata.
  - The other port's rdata = 0. rdata* = 0 whenever rvalid* = 0.
  - Arbitration for the next command happens in the same cycle (back-to-back).
- Outputs are Moore, decoded from registered state only. mem_addr and mem_wdata are 0 outside CMD.
- Latency from req sampled to gnt = 1 cycle. Read: rvalid 1 cycle after gnt.
- Throughput:
  - Writes: 1 per 2 cycles.
  - Reads: 1 per 2 cycles when requests are back-to-back (RESP→CMD); 1 per 3 cycles from idle.
- Requester rules:
  - Keep req/we/addr/wdata stable from assertion until gnt.
  - A req still high in the cycle after gnt counts as a new request.
- Command changes on the losing port before its gnt are sampled only at its eventual arbitration win; earlier values are ignored.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1…; neither port waits more than one foreign access.
- Widths: addresses pass unchanged with no wrap or range check. Out-of-range handling belongs to `dm`.

Test Plan:
- Reset, then port 0 write: req0 = 1, we0 = 1, addr0 = 2, wdata0 = 32'h00030002 → gnt0 plus mem_en = 1, mem_we = 1, mem_addr = 2 one cycle later; no rvalid0; next state IDLE.
- Port 0 read: addr0 = 1, dm[1] = 1 → gnt0 at cycle t, rvalid0 = 1 with rdata0 = 32'd1 at t+1; rvalid1 stays 0.
- Tie: both req continuously high, port 0 reads addr 4, port 1 reads addr 5 (dm[4] = 4, dm[5] = 5) → gnt0 first; gnt1 in the cycle after rvalid0 (back-to-back via RESP); rdata1 = 5; then alternation continues.
- Write/read ordering: port 1 writes addr 7 = 32'hDEADBEEF, then port 0 reads addr 7 → rdata0 = 32'hDEADBEEF.
- Reset mid-read: assert rst = 0 asynchronously during RESP → rvalid* drop immediately, state IDLE. After release with req0 = 1, tie-break favours port 0 (last_port = 1).
- Idle: no requests for 10 cycles → mem_en = 0, all gnt/rvalid = 0, mem_addr = 0 throughout.
